camera_init_sequencer: RTL and testbench
========================================

CAMERA_INIT_SEQUENCER -- requirements
Module: camera_init_sequencer

Interface
REQ-001 The parameter StepCycles SHALL default to 500000 and SHALL give the clk cycles each startup_sequencer bit is held.
REQ-002 The parameter CmdHoldCycles SHALL default to 16 and SHALL give the clk cycles send_special_i2c_command is held high.
REQ-003 The parameter CmdGapCycles SHALL default to 500000 and SHALL give the low time after a special command before the next one is accepted.
REQ-004 clk  in  1  The single clock; all logic SHALL be rising-edge.
REQ-005 reset_n  in  1  The reset SHALL be synchronous and active-low.
REQ-006 start_init  in  1  A high level SHALL request the camera startup write sequence.
REQ-007 host_cmd_valid  in  1  A high level SHALL mean a host register write is offered.
REQ-008 host_cmd_register  in  8  The offered camera register address.
REQ-009 host_cmd_data  in  16  The offered camera register value.
REQ-010 host_cmd_ready  out  1  A high level SHALL mean the block accepts the offered command this cycle.
REQ-011 startup_sequencer  out  18  The one-hot step vector to the I2C writer; even bits SHALL be write steps and odd bits SHALL be gaps.
REQ-012 send_special_i2c_command  out  1  The special-write request to the I2C writer.
REQ-013 special_i2c_command_register  out  8  The latched register for the special write.
REQ-014 special_i2c_command_data  out  16  The latched data for the special write.
REQ-015 init_done  out  1  A high level SHALL mean the startup sequence has completed.
REQ-016 busy  out  1  busy SHALL be high in every state except IDLE and READY.

Function
REQ-017 The block SHALL implement the FSM states IDLE, INIT_STEP, READY, CMD_ASSERT and CMD_GAP, with one 32-bit down-counter and a 5-bit step index.
REQ-018 IDLE: when start_init=1, the FSM SHALL enter INIT_STEP with step index 0, startup_sequencer=18'h00001 and the counter loaded with StepCycles-1.
REQ-019 INIT_STEP: the counter SHALL decrement each cycle; when it reaches 0 and index<17, the block SHALL increment the index, shift the one-hot bit left by one and reload the counter.
REQ-020 Each startup_sequencer bit SHALL be high for exactly StepCycles cycles, and exactly one bit SHALL be high throughout INIT_STEP.
REQ-021 When the counter reaches 0 at index 17, the block SHALL clear startup_sequencer to 0, set init_done=1 and enter READY on the next edge.
REQ-022 start_init SHALL be ignored in INIT_STEP, CMD_ASSERT and CMD_GAP.
REQ-023 host_cmd_valid SHALL be ignored outside READY; host_cmd_ready SHALL be low outside READY.
REQ-024 READY: host_cmd_ready SHALL equal 1 unless start_init=1.
  - A transfer SHALL occur when host_cmd_valid=1 and host_cmd_ready=1.
REQ-025 On a transfer, the block SHALL latch host_cmd_register and host_cmd_data into the special_* outputs, set send_special_i2c_command=1 on the next edge, load the counter with CmdHoldCycles-1 and enter CMD_ASSERT.
REQ-026 CMD_ASSERT: when the counter reaches 0, send_special_i2c_command SHALL drop to 0, the counter SHALL load CmdGapCycles-1 and the FSM SHALL enter CMD_GAP.
REQ-027 CMD_GAP: when the counter reaches 0, the FSM SHALL return to READY.
REQ-028 special_i2c_command_register and special_i2c_command_data SHALL hold their values from the end of CMD_ASSERT until the next transfer, covering the whole I2C transaction.
REQ-029 READY with start_init=1: start_init SHALL win over host_cmd_valid, with no transfer, init_done cleared, and INIT_STEP restarted at index 0.
REQ-030 startup_sequencer and send_special_i2c_command SHALL never be high in the same cycle.
REQ-031 All outputs SHALL be registered, except host_cmd_ready, which is a combinational decode of the state and start_init.

Reset
REQ-032 When reset_n=0 at a rising edge, the next state SHALL be IDLE, regardless of the current state, including mid-step or mid-command.
REQ-033 On that reset, the counter and index SHALL be cleared and startup_sequencer=0, send_special_i2c_command=0, special_i2c_command_register=0, special_i2c_command_data=0, init_done=0 and busy=0.

Verification (StepCycles=10, CmdHoldCycles=4, CmdGapCycles=20)
REQ-034 Bench: pulse start_init for 1 cycle after reset -> startup_sequencer walks 18'h00001..18'h20000 with each bit high 10 cycles, then init_done=1 after 180 cycles, with busy high throughout.
REQ-035 Bench: in READY, offer register 8'h20 and data 16'h0060 with valid=1 -> accepted in 1 cycle, send_special high 4 cycles, outputs hold 8'h20/16'h0060, ready low 24 cycles total.
REQ-036 Bench: hold valid high continuously with two different commands -> the second is accepted only after the 20-cycle gap, and the data outputs change only at the second accept.
REQ-037 Bench: assert start_init and valid together in READY -> no transfer, init_done clears, and startup_sequencer=18'h00001 on the next edge.
REQ-038 Bench: assert reset_n=0 for 1 cycle at step index 9 and separately in CMD_ASSERT -> all outputs 0 on the next edge, and the FSM in IDLE ignores valid.
REQ-039 Bench: pulse start_init during INIT_STEP and during CMD_GAP -> no effect on the step index or counter timing.

Source files
------------

// File: rtl/camera_init_sequencer.sv
// camera_init_sequencer: walks an 18-step one-hot startup vector, then forwards host register writes
// as timed special-command pulses followed by a settle gap.
module camera_init_sequencer #(
  parameter int StepCycles    = 500000,
  parameter int CmdHoldCycles = 16,
  parameter int CmdGapCycles  = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_init,
  input  logic        host_cmd_valid,
  input  logic [7:0]  host_cmd_register,
  input  logic [15:0] host_cmd_data,
  output logic        host_cmd_ready,
  output logic [17:0] startup_sequencer,
  output logic        send_special_i2c_command,
  output logic [7:0]  special_i2c_command_register,
  output logic [15:0] special_i2c_command_data,
  output logic        init_done,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, INIT_STEP, READY, CMD_ASSERT, CMD_GAP} state_t;
  localparam logic [31:0] StepLoad = 32'(StepCycles - 1);
  localparam logic [31:0] HoldLoad = 32'(CmdHoldCycles - 1);
  localparam logic [31:0] GapLoad  = 32'(CmdGapCycles - 1);
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [17:0] seq_q, seq_d;
  logic        send_q, send_d, done_q, done_d, busy_q;
  logic [7:0]  reg_q, reg_d;
  logic [15:0] data_q, data_d;
  assign host_cmd_ready = (state_q == READY) && !start_init;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    send_d  = send_q;
    done_d  = done_q;
    reg_d   = reg_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (start_init) begin
        state_d = INIT_STEP;
        idx_d   = 5'd0;
        seq_d   = 18'h00001;
        cnt_d   = StepLoad;
      end
      INIT_STEP: if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
        else if (idx_q < 5'd17) begin
          idx_d = idx_q + 5'd1;
          seq_d = seq_q << 1;
          cnt_d = StepLoad;
        end else begin
          seq_d   = 18'h0;
          done_d  = 1'b1;
          state_d = READY;
        end
      // start_init outranks a pending host write
      READY: if (start_init) begin
        state_d = INIT_STEP;
        idx_d   = 5'd0;
        seq_d   = 18'h00001;
        cnt_d   = StepLoad;
        done_d  = 1'b0;
      end else if (host_cmd_valid) begin
        reg_d   = host_cmd_register;
        data_d  = host_cmd_data;
        send_d  = 1'b1;
        cnt_d   = HoldLoad;
        state_d = CMD_ASSERT;
      end
      CMD_ASSERT: if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
        else begin
          send_d  = 1'b0;
          cnt_d   = GapLoad;
          state_d = CMD_GAP;
        end
      CMD_GAP: if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
        else state_d = READY;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      idx_q   <= 5'd0;
      seq_q   <= 18'h0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      reg_q   <= 8'h0;
      data_q  <= 16'h0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      send_q  <= send_d;
      done_q  <= done_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      busy_q  <= (state_d != IDLE) && (state_d != READY);
    end
  end
  assign startup_sequencer            = seq_q;
  assign send_special_i2c_command     = send_q;
  assign special_i2c_command_register = reg_q;
  assign special_i2c_command_data     = data_q;
  assign init_done                    = done_q;
  assign busy                         = busy_q;
endmodule

// File: tb/tb_camera_init_sequencer.sv
// tb_camera_init_sequencer: directed checks of startup walk, host writes, priority and reset.
module tb_camera_init_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_init = 1'b0;
  logic        host_cmd_valid = 1'b0;
  logic [7:0]  host_cmd_register = 8'h0;
  logic [15:0] host_cmd_data = 16'h0;
  logic        host_cmd_ready;
  logic [17:0] startup_sequencer;
  logic        send_special_i2c_command;
  logic [7:0]  special_i2c_command_register;
  logic [15:0] special_i2c_command_data;
  logic        init_done;
  logic        busy;
  int vectors = 0;
  int miscompares = 0;

  camera_init_sequencer #(.StepCycles(10), .CmdHoldCycles(4), .CmdGapCycles(20)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_init(start_init),
    .host_cmd_valid(host_cmd_valid),
    .host_cmd_register(host_cmd_register),
    .host_cmd_data(host_cmd_data),
    .host_cmd_ready(host_cmd_ready),
    .startup_sequencer(startup_sequencer),
    .send_special_i2c_command(send_special_i2c_command),
    .special_i2c_command_register(special_i2c_command_register),
    .special_i2c_command_data(special_i2c_command_data),
    .init_done(init_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_seq"}, 32'(startup_sequencer), 32'h0);
    chk({tag, "_send"}, 32'(send_special_i2c_command), 32'h0);
    chk({tag, "_reg"}, 32'(special_i2c_command_register), 32'h0);
    chk({tag, "_data"}, 32'(special_i2c_command_data), 32'h0);
    chk({tag, "_done"}, 32'(init_done), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic run_init(input string tag);
    start_init = 1'b1;
    tick();
    start_init = 1'b0;
    for (int k = 0; k < 180; k++) begin
      chk({tag, "_seq"}, 32'(startup_sequencer), 32'(1) << (k / 10));
      chk({tag, "_busy"}, 32'(busy), 32'h1);
      chk({tag, "_done"}, 32'(init_done), 32'h0);
      start_init = (k == 55);
      tick();
    end
    start_init = 1'b0;
    chk({tag, "_end_seq"}, 32'(startup_sequencer), 32'h0);
    chk({tag, "_end_done"}, 32'(init_done), 32'h1);
    chk({tag, "_end_busy"}, 32'(busy), 32'h0);
    chk({tag, "_end_ready"}, 32'(host_cmd_ready), 32'h1);
  endtask

  initial begin
    tick();
    tick();
    chk_all_zero("reset");
    chk("reset_ready", 32'(host_cmd_ready), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    run_init("init1");

    host_cmd_register = 8'h20;
    host_cmd_data = 16'h0060;
    host_cmd_valid = 1'b1;
    #1;
    chk("cmd1_ready_pre", 32'(host_cmd_ready), 32'h1);
    tick();
    host_cmd_valid = 1'b0;
    chk("cmd1_reg", 32'(special_i2c_command_register), 32'h20);
    chk("cmd1_data", 32'(special_i2c_command_data), 32'h0060);
    chk("cmd1_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 24; k++) begin
      chk("cmd1_ready_low", 32'(host_cmd_ready), 32'h0);
      chk("cmd1_send", 32'(send_special_i2c_command), 32'(k < 4));
      chk("cmd1_seq_off", 32'(startup_sequencer), 32'h0);
      start_init = (k == 10);
      tick();
    end
    start_init = 1'b0;
    #1;
    chk("cmd1_ready_back", 32'(host_cmd_ready), 32'h1);
    chk("cmd1_busy_back", 32'(busy), 32'h0);
    chk("cmd1_reg_hold", 32'(special_i2c_command_register), 32'h20);
    chk("cmd1_data_hold", 32'(special_i2c_command_data), 32'h0060);
    chk("cmd1_done_kept", 32'(init_done), 32'h1);

    host_cmd_register = 8'h31;
    host_cmd_data = 16'hABCD;
    host_cmd_valid = 1'b1;
    tick();
    host_cmd_register = 8'h42;
    host_cmd_data = 16'h1234;
    for (int k = 0; k < 24; k++) begin
      chk("b2b_reg_first", 32'(special_i2c_command_register), 32'h31);
      chk("b2b_data_first", 32'(special_i2c_command_data), 32'hABCD);
      chk("b2b_ready_low", 32'(host_cmd_ready), 32'h0);
      tick();
    end
    chk("b2b_ready_back", 32'(host_cmd_ready), 32'h1);
    chk("b2b_send_idle", 32'(send_special_i2c_command), 32'h0);
    tick();
    host_cmd_valid = 1'b0;
    chk("b2b_reg_second", 32'(special_i2c_command_register), 32'h42);
    chk("b2b_data_second", 32'(special_i2c_command_data), 32'h1234);
    chk("b2b_send_second", 32'(send_special_i2c_command), 32'h1);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_all_zero("rst_cmd");
    chk("rst_cmd_ready", 32'(host_cmd_ready), 32'h0);
    host_cmd_register = 8'h77;
    host_cmd_data = 16'h5555;
    host_cmd_valid = 1'b1;
    #1;
    chk("idle_ready_low", 32'(host_cmd_ready), 32'h0);
    tick();
    host_cmd_valid = 1'b0;
    chk_all_zero("idle_ignores_valid");

    start_init = 1'b1;
    tick();
    start_init = 1'b0;
    repeat (95) tick();
    chk("step9_seq", 32'(startup_sequencer), 32'h00200);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_all_zero("rst_step9");

    run_init("init2");
    start_init = 1'b1;
    host_cmd_valid = 1'b1;
    host_cmd_register = 8'h55;
    host_cmd_data = 16'h7777;
    #1;
    chk("prio_ready", 32'(host_cmd_ready), 32'h0);
    tick();
    start_init = 1'b0;
    host_cmd_valid = 1'b0;
    chk("prio_done", 32'(init_done), 32'h0);
    chk("prio_seq", 32'(startup_sequencer), 32'h00001);
    chk("prio_send", 32'(send_special_i2c_command), 32'h0);
    chk("prio_reg", 32'(special_i2c_command_register), 32'h0);
    chk("prio_busy", 32'(busy), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
